// File: rtl/tapa_ap_ctrl_share_arb.sv
// Round-robin arbiter time-sharing one ap_ctrl_hs child among NUM_REQ requesters.
// Optional performance counters are enabled by defining TAPA_ARB_PERF_EN.
module tapa_ap_ctrl_share_arb #(
  parameter int NUM_REQ   = 4,
  parameter int ARG_W     = 64,
  parameter int REQ_IDX_W = $clog2(NUM_REQ)
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic [NUM_REQ-1:0]       req_ap_start,
  input  logic [NUM_REQ*ARG_W-1:0] req_args,
  output logic [NUM_REQ-1:0]       req_ap_ready,
  output logic [NUM_REQ-1:0]       req_ap_done,
  output logic [NUM_REQ-1:0]       req_ap_idle,
  output logic                     child_ap_start,
  output logic [ARG_W-1:0]         child_args,
  input  logic                     child_ap_ready,
  input  logic                     child_ap_done,
  input  logic                     child_ap_idle,
  output logic [REQ_IDX_W-1:0]     grant_idx,
  output logic                     busy
`ifdef TAPA_ARB_PERF_EN
  ,
  output logic [31:0]              perf_busy_cycles,
  output logic [31:0]              perf_grants
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_START = 2'b01,
    S_RUN   = 2'b11,
    S_DONE  = 2'b10
  } state_t;

  state_t               state;
  logic [REQ_IDX_W-1:0] rr_ptr;
  logic                 pick_valid;
  logic [REQ_IDX_W-1:0] pick_idx;
  logic [ARG_W-1:0]     pick_args;
  int                   cand;
  logic [REQ_IDX_W-1:0] cand_idx;

  // The child's idle is informational only; it never gates a transition.
  wire unused_child_idle = &{1'b0, child_idle_sink()};
  function automatic logic child_idle_sink();
    return child_ap_idle;
  endfunction

  // Scan downward from the farthest offset so the first set bit at or after
  // rr_ptr is the one left standing.
  // NOTE: every variable assigned in always_comb gets a default up front, so
  // no path leaves it holding a stale value and no latch is inferred.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = REQ_IDX_W'(cand);
      if (req_ap_start[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
    pick_args = req_args[int'(pick_idx)*ARG_W +: ARG_W];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state          <= S_IDLE;
      rr_ptr         <= '0;
      grant_idx      <= '0;
      child_args     <= '0;
      child_ap_start <= 1'b0;
      busy           <= 1'b0;
      req_ap_done    <= '0;
    end else begin
      req_ap_done <= '0;
      unique case (state)
        S_IDLE: begin
          if (pick_valid) begin
            grant_idx      <= pick_idx;
            child_args     <= pick_args;
            child_ap_start <= 1'b1;
            busy           <= 1'b1;
            state          <= S_START;
          end
        end
        S_START: begin
          if (child_ap_ready) begin
            child_ap_start <= 1'b0;
            if (child_ap_done) begin
              req_ap_done[grant_idx] <= 1'b1;
              state                  <= S_DONE;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (child_ap_done) begin
            req_ap_done[grant_idx] <= 1'b1;
            state                  <= S_DONE;
          end
        end
        S_DONE: begin
          if (grant_idx == REQ_IDX_W'(NUM_REQ - 1)) rr_ptr <= '0;
          else                                      rr_ptr <= grant_idx + 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ap_ready = req_ap_done;

  always_comb begin
    req_ap_idle = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_ap_idle[i] = ~req_ap_start[i] & ~(busy & (grant_idx == REQ_IDX_W'(i)));
  end

`ifdef TAPA_ARB_PERF_EN
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      perf_busy_cycles <= '0;
      perf_grants      <= '0;
    end else begin
      if (busy && perf_busy_cycles != 32'hFFFF_FFFF)
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (state == S_IDLE && pick_valid && perf_grants != 32'hFFFF_FFFF)
        perf_grants <= perf_grants + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tapa_ap_ctrl_share_arb.sv
// Directed self-checking bench for tapa_ap_ctrl_share_arb (NUM_REQ=4, ARG_W=64).
// Inputs change 1 ns after the rising edge; outputs are checked at the same point.
module tb_tapa_ap_ctrl_share_arb;
  localparam int NUM_REQ   = 4;
  localparam int ARG_W     = 64;
  localparam int REQ_IDX_W = 2;

  logic                     ap_clk = 1'b0;
  logic                     ap_rst = 1'b1;
  logic [NUM_REQ-1:0]       req_ap_start = '0;
  logic [NUM_REQ*ARG_W-1:0] req_args = '0;
  logic [NUM_REQ-1:0]       req_ap_ready, req_ap_done, req_ap_idle;
  logic                     child_ap_start;
  logic [ARG_W-1:0]         child_args;
  logic                     child_ap_ready = 1'b0;
  logic                     child_ap_done  = 1'b0;
  logic                     child_ap_idle  = 1'b1;
  logic [REQ_IDX_W-1:0]     grant_idx;
  logic                     busy;
`ifdef TAPA_ARB_PERF_EN
  logic [31:0]              perf_busy_cycles, perf_grants;
`endif

  tapa_ap_ctrl_share_arb #(.NUM_REQ(NUM_REQ), .ARG_W(ARG_W)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_ap_start(req_ap_start), .req_args(req_args),
    .req_ap_ready(req_ap_ready), .req_ap_done(req_ap_done), .req_ap_idle(req_ap_idle),
    .child_ap_start(child_ap_start), .child_args(child_args),
    .child_ap_ready(child_ap_ready), .child_ap_done(child_ap_done), .child_ap_idle(child_ap_idle),
    .grant_idx(grant_idx), .busy(busy)
`ifdef TAPA_ARB_PERF_EN
    , .perf_busy_cycles(perf_busy_cycles), .perf_grants(perf_grants)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt[NUM_REQ] = '{default: 0};
  int proto_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_args(input int i, input logic [63:0] v);
    req_args[i*ARG_W +: ARG_W] = v;
  endtask

  // Pulse bookkeeping: ready must mirror done, and at most one bit may be high.
  always @(negedge ap_clk) begin
    if (!ap_rst) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (req_ap_done[i] === 1'b1) done_cnt[i]++;
      if (req_ap_ready !== req_ap_done || $countones(req_ap_done) > 1) proto_err++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap0;
    logic [REQ_IDX_W-1:0] rr_exp [5];
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset state while ap_rst is held
    #2;
    check("rst_busy",   64'(busy), 64'd0);
    check("rst_cstart", 64'(child_ap_start), 64'd0);
    check("rst_grant",  64'(grant_idx), 64'd0);
    check("rst_cargs",  child_args, 64'd0);
    check("rst_idle",   64'(req_ap_idle), 64'hF);
    check("rst_done",   64'(req_ap_done), 64'd0);
    step(); step();
    ap_rst = 1'b0;
    step();

    // child done in IDLE is ignored
    child_ap_done = 1'b1;
    step();
    check("idle_done_ignored", 64'(busy), 64'd0);
    child_ap_done = 1'b0;

    // Single request from requester 2; ready 3 cycles, done 6 cycles after start
    set_args(0, 64'h10); set_args(1, 64'h11); set_args(2, 64'hA5); set_args(3, 64'h13);
    req_ap_start = 4'b0100;
    step();
    check("single_grant",  64'(grant_idx), 64'd2);
    check("single_cargs",  child_args, 64'hA5);
    check("single_cstart", 64'(child_ap_start), 64'd1);
    check("single_idle",   64'(req_ap_idle), 64'hB);
    for (int c = 0; c <= 6; c++) begin
      child_ap_ready = (c == 3);
      child_ap_done  = (c == 6);
      step();
      if (c == 3) check("single_run_cstart", 64'(child_ap_start), 64'd0);
      if (c == 5) check("single_run_nodone", 64'(req_ap_done), 64'd0);
    end
    child_ap_ready = 1'b0; child_ap_done = 1'b0;
    check("single_done",  64'(req_ap_done), 64'h4);
    check("single_ready", 64'(req_ap_ready), 64'h4);
    req_ap_start = 4'b0000;
    step();
    check("single_busy_after", 64'(busy), 64'd0);
    check("single_done_after", 64'(req_ap_done), 64'd0);

    // Done without ready in START is ignored; then ready+done together skips RUN
    req_ap_start = 4'b0010;
    step();
    check("sim_grant", 64'(grant_idx), 64'd1);
    child_ap_done = 1'b1;
    step();
    check("start_done_ignored", 64'(child_ap_start), 64'd1);
    child_ap_ready = 1'b1;
    step();
    child_ap_ready = 1'b0; child_ap_done = 1'b0;
    check("sim_done_direct", 64'(req_ap_done), 64'h2);
    req_ap_start = 4'b0000;
    step();
    check("sim_busy_after", 64'(busy), 64'd0);

    // Arg stability, plus ready outside START is ignored
    set_args(1, 64'h1);
    req_ap_start = 4'b0010;
    step();
    check("args_grant", 64'(grant_idx), 64'd1);
    child_ap_ready = 1'b1;
    step();
    set_args(1, 64'h2);
    step();
    check("args_run_stable", child_args, 64'h1);
    check("run_ready_ignored", 64'(req_ap_done), 64'd0);
    check("run_busy", 64'(busy), 64'd1);
    child_ap_ready = 1'b0; child_ap_done = 1'b1;
    step();
    child_ap_done = 1'b0;
    check("args_done_pulse", 64'(req_ap_done), 64'h2);
    check("args_done_stable", child_args, 64'h1);
    req_ap_start = 4'b0000;
    step();

    // Reset mid-RUN aborts with no done pulse
    req_ap_start = 4'b0001;
    step();
    check("rstrun_grant", 64'(grant_idx), 64'd0);
    child_ap_ready = 1'b1;
    step();
    child_ap_ready = 1'b0;
    snap0 = done_cnt[0];
    req_ap_start = 4'b0000;
    ap_rst = 1'b1;
    #1;
    check("rstrun_busy",   64'(busy), 64'd0);
    check("rstrun_cstart", 64'(child_ap_start), 64'd0);
    check("rstrun_idle",   64'(req_ap_idle), 64'hF);
    step();
    ap_rst = 1'b0;
    child_ap_done = 1'b1;
    step(); step();
    child_ap_done = 1'b0;
    check("rstrun_no_done", 64'(done_cnt[0]), 64'(snap0));
    check("rstrun_idle_after", 64'(busy), 64'd0);

    // Round-robin with all four held, child ready+done one cycle after start
    req_ap_start = 4'b1111;
    child_ap_ready = 1'b1; child_ap_done = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("rr_grant_%0d", k), 64'(grant_idx), 64'(rr_exp[k]));
      step();
      check($sformatf("rr_done_%0d", k), 64'(req_ap_done), 64'd1 << rr_exp[k]);
      step();
    end
    req_ap_start = 4'b0000;
    child_ap_ready = 1'b0; child_ap_done = 1'b0;
    step();

    // Cumulative pulse counts from all services above
    check("cnt_req0", 64'(done_cnt[0]), 64'd2);
    check("cnt_req1", 64'(done_cnt[1]), 64'd3);
    check("cnt_req2", 64'(done_cnt[2]), 64'd2);
    check("cnt_req3", 64'(done_cnt[3]), 64'd1);
    check("pulse_protocol", 64'(proto_err), 64'd0);

`ifdef TAPA_ARB_PERF_EN
    ap_rst = 1'b1;
    step();
    ap_rst = 1'b0;
    check("perf_rst", 64'(perf_busy_cycles), 64'd0);
    // Three services of five busy cycles each: START x2, RUN x2, DONE x1
    for (int s = 0; s < 3; s++) begin
      req_ap_start = 4'b1000;
      step();
      for (int c = 0; c <= 3; c++) begin
        child_ap_ready = (c == 1);
        child_ap_done  = (c == 3);
        step();
      end
      child_ap_ready = 1'b0; child_ap_done = 1'b0;
      req_ap_start = 4'b0000;
      step();
    end
    check("perf_grants", 64'(perf_grants), 64'd3);
    check("perf_busy_cycles", 64'(perf_busy_cycles), 64'd15);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tapa_ap_ctrl_share_arb.md
Name: tapa_ap_ctrl_share_arb

Overview:
- Time-shares one ap_ctrl_hs child task instance among NUM_REQ requesters.
- Each requester sees its own ap_start/ap_ready/ap_done/ap_idle interface plus a scalar argument bundle.
- The arbiter grants the child round-robin, latches the winner's scalars, sequences the child's start/ready/done handshake, and returns completion to the winner.
- Sits in a slot wrapper between the slot-level task FSMs and a single shared child (e.g. one Mmap2Stream used by several producers).

Parameters:
- NUM_REQ, 4, number of requesters, 2..16.
- ARG_W, 64, width of one requester's scalar bundle.
- REQ_IDX_W, $clog2(NUM_REQ), grant index width (derived).

Ports:
- ap_clk  in  1  clock.
- ap_rst  in  1  asynchronous reset, active-high.
- req_ap_start  in  NUM_REQ  per-requester start, level; held until that requester's ready.
- req_args  in  NUM_REQ*ARG_W  scalar bundle; requester i in [i*ARG_W +: ARG_W].
- req_ap_ready  out  NUM_REQ  one-cycle pulse; request accepted and completed.
- req_ap_done  out  NUM_REQ  one-cycle pulse, coincident with req_ap_ready.
- req_ap_idle  out  NUM_REQ  high when the requester is neither granted nor in service.
- child_ap_start  out  1  start to shared child.
- child_args  out  ARG_W  latched scalars of the granted requester.
- child_ap_ready  in  1  child ready.
- child_ap_done  in  1  child done.
- child_ap_idle  in  1  child idle; observed only, does not gate transitions.
- grant_idx  out  REQ_IDX_W  index of the current or most recent grant.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, rr_ptr=0, grant_idx=0, child_args=0.
  - All outputs low except req_ap_idle=all ones.
- States: IDLE(2'b00), START(2'b01), RUN(2'b11), DONE(2'b10), registered.
- IDLE:
  - If any req_ap_start bit is set, pick the first set bit scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - Register grant_idx and child_args <= req_args[grant].
  - Go to START. The grant is visible the cycle after the request is seen.
- START:
  - child_ap_start=1.
  - On child_ap_ready: go to DONE if child_ap_done is also high that cycle, otherwise RUN.
- RUN:
  - child_ap_start=0.
  - On child_ap_done: go to DONE.
- DONE:
  - req_ap_ready[grant_idx]=req_ap_done[grant_idx]=1 for exactly this cycle.
  - rr_ptr <= grant_idx+1, wrapping to 0 at NUM_REQ-1.
  - Go to IDLE.
- Minimum grant-to-grant spacing is 1 cycle in IDLE. Back-to-back service latency is DONE→IDLE→START.
- child_ap_done seen in IDLE or START-without-ready: ignored.
- child_ap_ready seen outside START: ignored.
- child_args:
  - Stable from START entry through DONE.
  - Changes to req_args during service do not propagate.
- A requester that drops req_ap_start after being granted still completes. Its ready/done still pulse.
- Requests arriving during service stay pending (level-held) and are arbitrated in the next IDLE.
- req_ap_idle[i] = ~req_ap_start[i] & ~(busy & grant_idx==i).
- Only one requester's ready/done is ever high in a cycle.
- ap_rst asserted mid-service aborts to IDLE with no done pulse. The child is assumed to be reset by the same ap_rst.

Optional Feature:
- Macro: TAPA_ARB_PERF_EN.
- Defined:
  - Adds output perf_busy_cycles[31:0], which increments every cycle busy=1.
  - Adds output perf_grants[31:0], which increments on each IDLE→START transition.
  - Both counters saturate at 32'hFFFFFFFF and are cleared by ap_rst.
- Undefined: neither port nor the counter registers exist. All other behaviour is identical.

Test Plan:
- Single request: req_ap_start=4'b0100, req_args[2]=64'hA5; child ready at cycle 3 and done at cycle 6 after start → grant_idx=2, child_args=64'hA5, one req_ap_done[2] pulse in the cycle after the child done, busy low the cycle after that.
- Round-robin: all four req_ap_start held high, child does ready+done together 1 cycle after each start → grant order 0,1,2,3,0; each requester gets exactly one done per service.
- Simultaneous ready and done in START → START→DONE directly; RUN never entered; single done pulse.
- Arg stability: change req_args[1] from 64'h1 to 64'h2 during RUN → child_args stays 64'h1 until DONE.
- Reset mid-RUN: assert ap_rst for 1 cycle → state=IDLE, child_ap_start=0, no req_ap_done pulse, req_ap_idle=4'b1111 while no requests are held.
- With TAPA_ARB_PERF_EN, 3 services of 5 busy cycles each → perf_grants=3, perf_busy_cycles=15.
